// File: rtl/and3_chk_pkg.sv
// Shared types and helpers for the and3 result checker.
// The optional capture feature is controlled by the macro AND3_CHK_CAPTURE_EN.
package and3_chk_pkg;

    localparam int MAX_LATENCY = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counters up to 32 bits wide are increased through this helper; max is the all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/and3_chk_delay.sv
// {valid, payload} delay line aligning golden samples with the DUT output.
// Payload is 1 bit, or 4 bits ({exp, i1, i2, i3}) when AND3_CHK_CAPTURE_EN is defined.
module and3_chk_delay
    import and3_chk_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int PW    = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [PW-1:0] in_pay,
    output logic          out_vld,
    output logic [PW-1:0] out_pay
);

    if (DEPTH < 1 || DEPTH > MAX_LATENCY) begin : g_bad_depth
        $error("and3_chk_delay: DEPTH must be 1..%0d", MAX_LATENCY);
    end

    logic [DEPTH-1:0]         vld_pipe;
    logic [DEPTH-1:0][PW-1:0] pay_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            pay_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld & ~flush;
            pay_pipe[0] <= in_pay;
            for (int s = 1; s < DEPTH; s++) begin
                vld_pipe[s] <= vld_pipe[s-1] & ~flush;
                pay_pipe[s] <= pay_pipe[s-1];
            end
        end
    end

    assign out_vld = vld_pipe[DEPTH-1];
    assign out_pay = pay_pipe[DEPTH-1];

endmodule

// File: rtl/and3_result_checker.sv
// Self-checking stage: delays the golden i1&i2&i3 by LATENCY cycles and scores o1 against it.
// Defining AND3_CHK_CAPTURE_EN adds first_fail_idx / first_fail_vec capture outputs.
module and3_result_checker
    import and3_chk_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] run_len,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    input  logic             o1,
    output logic             checking,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef AND3_CHK_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [2:0]       first_fail_vec
`endif
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_lat
        $error("and3_result_checker: LATENCY must be 1..%0d", MAX_LATENCY);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("and3_result_checker: CNT_W must be 1..32");
    end

`ifdef AND3_CHK_CAPTURE_EN
    localparam int PW = 4;
`else
    localparam int PW = 1;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), 32'(CNT_MAX)));
    endfunction

    logic [1:0]       state;
    logic [3:0]       fill_cnt;
    logic [CNT_W-1:0] check_cnt, check_nxt, run_len_q;
    logic             active, flush, cmp, match, tail_vld;
    logic [PW-1:0]    pay_in, tail_pay;

`ifdef AND3_CHK_CAPTURE_EN
    assign pay_in = {i1 & i2 & i3, i1, i2, i3};
`else
    assign pay_in = i1 & i2 & i3;
`endif

    // Sampling only while a run is live; anything else empties the delay line.
    assign active    = (state == ST_FILL || state == ST_CHECK) && enable && !clear;
    assign flush     = !active;
    assign cmp       = active && (state == ST_CHECK) && tail_vld;
    assign match     = (o1 === tail_pay[PW-1]);
    assign check_nxt = inc(check_cnt);

    and3_chk_delay #(.DEPTH(LATENCY), .PW(PW)) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .in_vld  (active),
        .in_pay  (pay_in),
        .out_vld (tail_vld),
        .out_pay (tail_pay)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            check_cnt <= '0;
            run_len_q <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            error     <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            check_cnt <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (enable) begin
                    state     <= ST_FILL;
                    fill_cnt  <= '0;
                    check_cnt <= '0;
                    run_len_q <= run_len;
                end
                ST_FILL: begin
                    if (!enable)                           state    <= ST_IDLE;
                    else if (fill_cnt == 4'(LATENCY - 1))  state    <= ST_CHECK;
                    else                                   fill_cnt <= fill_cnt + 4'd1;
                end
                ST_CHECK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (cmp) begin
                        check_cnt <= check_nxt;
                        // Saturated check count still hits an all-ones run_len.
                        if (run_len_q != '0 && check_nxt == run_len_q) state <= ST_DONE;
                    end
                end
                ST_DONE: if (!enable) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (cmp) begin
                if (match) begin
                    pass_cnt <= inc(pass_cnt);
                end else begin
                    fail_cnt <= inc(fail_cnt);
                    error    <= 1'b1;
                end
            end
        end
    end

    assign checking = (state == ST_CHECK);
    assign done     = (state == ST_DONE);

`ifdef AND3_CHK_CAPTURE_EN
    logic captured;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            captured       <= 1'b0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
        end else if (clear) begin
            captured       <= 1'b0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
        end else begin
            // Re-arm per run; the previous capture stays visible until a new one lands.
            if (state == ST_IDLE && enable) captured <= 1'b0;
            if (cmp && !match && !captured) begin
                captured       <= 1'b1;
                first_fail_idx <= check_cnt;
                first_fail_vec <= tail_pay[2:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_and3_result_checker.sv
// Bench: two checker instances (LATENCY=1/CNT_W=4 and LATENCY=3/CNT_W=16) share stimulus
// and are scored every cycle against a run-level reference model.
module tb_and3_result_checker;

    localparam int LA = 1, WA = 4, LB = 3, WB = 16;

    logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, enable = 1'b0;
    logic [15:0] run_len = '0;
    logic i1 = 1'b0, i2 = 1'b0, i3 = 1'b0, o1a = 1'b0, o1b = 1'b0;
    logic chk_a, done_a, err_a, chk_b, done_b, err_b;
    logic [WA-1:0] pass_a, fail_a;
    logic [WB-1:0] pass_b, fail_b;
`ifdef AND3_CHK_CAPTURE_EN
    logic [WA-1:0] ffi_a;
    logic [WB-1:0] ffi_b;
    logic [2:0]    ffv_a, ffv_b;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    and3_result_checker #(.LATENCY(LA), .CNT_W(WA)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .run_len(run_len[WA-1:0]),
        .i1(i1), .i2(i2), .i3(i3), .o1(o1a),
        .checking(chk_a), .done(done_a), .error(err_a), .pass_cnt(pass_a), .fail_cnt(fail_a)
`ifdef AND3_CHK_CAPTURE_EN
        , .first_fail_idx(ffi_a), .first_fail_vec(ffv_a)
`endif
    );

    and3_result_checker #(.LATENCY(LB), .CNT_W(WB)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .run_len(run_len),
        .i1(i1), .i2(i2), .i3(i3), .o1(o1b),
        .checking(chk_b), .done(done_b), .error(err_b), .pass_cnt(pass_b), .fail_cnt(fail_b)
`ifdef AND3_CHK_CAPTURE_EN
        , .first_fail_idx(ffi_b), .first_fail_vec(ffv_b)
`endif
    );

    // Reference model: age = edges since the run started (-1 when no run is live).
    int lat  [2] = '{LA, LB};
    int cmax [2] = '{(1 << WA) - 1, (1 << WB) - 1};
    int m_age [2], m_nchk [2], m_np [2], m_nc [2], m_rl [2], m_pass [2], m_fail [2], m_cidx [2];
    bit m_done [2], m_err [2], m_capd [2];
    logic [2:0] m_cvec [2];
    logic [2:0] m_smp [2][0:255];
    logic [2:0] hist [0:255];
    logic [2:0] vecs [0:31];
    int ecnt = 0, mode = 0;

    function automatic int sat(input int v, input int k);
        return (v >= cmax[k]) ? v : v + 1;
    endfunction

    task automatic model_reset(input int k);
        m_age[k] = -1; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_err[k] = 0;
        m_cidx[k] = 0; m_cvec[k] = 3'b0; m_capd[k] = 0; m_nchk[k] = 0; m_np[k] = 0; m_nc[k] = 0;
    endtask

    task automatic model_step(input int k, input logic en, input logic clr, input logic [15:0] rl,
                              input logic [2:0] v, input logic o);
        logic [2:0] s;
        if (clr) begin
            model_reset(k);
        end else if (m_done[k]) begin
            if (!en) m_done[k] = 0;
        end else if (m_age[k] < 0) begin
            if (en) begin
                m_age[k] = 0; m_np[k] = 0; m_nc[k] = 0; m_nchk[k] = 0; m_capd[k] = 0;
                m_rl[k] = int'(rl) & cmax[k];
            end
        end else if (!en) begin
            m_age[k] = -1;
        end else begin
            m_smp[k][m_np[k] % 256] = v;
            m_np[k]++;
            if (m_age[k] >= lat[k]) begin
                s = m_smp[k][m_nc[k] % 256];
                if (o === (&s)) m_pass[k] = sat(m_pass[k], k);
                else begin
                    m_fail[k] = sat(m_fail[k], k);
                    m_err[k] = 1;
                    if (!m_capd[k]) begin m_cidx[k] = m_nchk[k]; m_cvec[k] = s; m_capd[k] = 1; end
                end
                m_nc[k]++;
                m_nchk[k] = sat(m_nchk[k], k);
                if (m_rl[k] != 0 && m_nchk[k] == m_rl[k]) begin m_done[k] = 1; m_age[k] = -1; end
            end
            if (!m_done[k]) m_age[k]++;
        end
    endtask

    // Behavioural DUT output with optional fault modes.
    function automatic logic o_for(input int k);
        logic b;
        logic [2:0] h;
        h = hist[(ecnt - lat[k]) % 256];
        b = (ecnt >= lat[k]) ? (&h) : 1'b0;
        case (mode)
            1: if (m_age[k] >= lat[k] && m_nc[k] == 5) b = ~b;
            2: b = 1'bx;
            3: b = 1'b0;
            4: if ($urandom_range(0, 7) == 0) b = ~b;
            default: ;
        endcase
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a.checking", 32'(chk_a),  32'(m_age[0] >= lat[0]));
        check("a.done",     32'(done_a), 32'(m_done[0]));
        check("a.error",    32'(err_a),  32'(m_err[0]));
        check("a.pass_cnt", 32'(pass_a), 32'(m_pass[0]));
        check("a.fail_cnt", 32'(fail_a), 32'(m_fail[0]));
        check("b.checking", 32'(chk_b),  32'(m_age[1] >= lat[1]));
        check("b.done",     32'(done_b), 32'(m_done[1]));
        check("b.error",    32'(err_b),  32'(m_err[1]));
        check("b.pass_cnt", 32'(pass_b), 32'(m_pass[1]));
        check("b.fail_cnt", 32'(fail_b), 32'(m_fail[1]));
`ifdef AND3_CHK_CAPTURE_EN
        check("a.first_fail_idx", 32'(ffi_a), 32'(m_cidx[0]));
        check("a.first_fail_vec", 32'(ffv_a), 32'(m_cvec[0]));
        check("b.first_fail_idx", 32'(ffi_b), 32'(m_cidx[1]));
        check("b.first_fail_vec", 32'(ffv_b), 32'(m_cvec[1]));
`endif
    endtask

    task automatic set_vec(input logic [2:0] v);
        {i1, i2, i3} = v;
    endtask

    // One clock: drive o1, let the edge happen, advance the model, compare.
    task automatic tick();
        logic [2:0] v;
        v = {i1, i2, i3};
        hist[ecnt % 256] = v;
        o1a = o_for(0);
        o1b = o_for(1);
        @(posedge clk);
        model_step(0, enable, clear, run_len, v, o1a);
        model_step(1, enable, clear, run_len, v, o1b);
        ecnt++;
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        model_reset(0); model_reset(1);
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // All eight combos, correct DUT, run_len=8; done after the 10th edge for LATENCY=1.
        run_len = 16'd8; mode = 0; enable = 1'b1;
        for (int n = 0; n < 16; n++) begin
            set_vec(3'(n + 7));
            tick();
            if (n == 8) check("a.done_early", 32'(done_a), 32'd0);
            if (n == 9) check("a.done_on_time", 32'(done_a), 32'd1);
        end
        check("a.pass8", 32'(pass_a), 32'd8);
        check("a.fail0", 32'(fail_a), 32'd0);
        check("b.pass8", 32'(pass_b), 32'd8);
        enable = 1'b0; tick();
        do_clear();

        // Fault on check index 5.
        mode = 1; enable = 1'b1;
        for (int n = 0; n < 16; n++) begin
            vecs[n] = 3'($urandom);
            set_vec(vecs[n]);
            tick();
        end
        check("a.fault_pass", 32'(pass_a), 32'd7);
        check("a.fault_fail", 32'(fail_a), 32'd1);
        check("a.fault_err",  32'(err_a),  32'd1);
`ifdef AND3_CHK_CAPTURE_EN
        check("a.fault_idx", 32'(ffi_a), 32'd5);
        check("a.fault_vec", 32'(ffv_a), 32'(vecs[6]));
        check("b.fault_vec", 32'(ffv_b), 32'(vecs[6]));
`endif
        enable = 1'b0; tick();
        do_clear();

        // Abort after 3 comparisons, then X on o1, then re-enable.
        run_len = 16'd0; mode = 0; enable = 1'b1;
        for (int n = 0; n < 5; n++) begin set_vec(3'($urandom)); tick(); end
        enable = 1'b0; mode = 2;
        for (int n = 0; n < 4; n++) begin set_vec(3'($urandom)); tick(); end
        check("a.abort_pass", 32'(pass_a), 32'd3);
        check("a.abort_fail", 32'(fail_a), 32'd0);
        mode = 0; enable = 1'b1;
        tick();
        check("a.refill_chk0", 32'(chk_a), 32'd0);
        tick();
        check("a.refill_chk1", 32'(chk_a), 32'd1);
        for (int n = 0; n < 4; n++) begin set_vec(3'($urandom)); tick(); end
        enable = 1'b0; tick();
        do_clear();

        // Saturation: stuck-at-0 output against 111.
        mode = 3; set_vec(3'b111); enable = 1'b1;
        for (int n = 0; n < 22; n++) tick();
        check("a.sat_fail", 32'(fail_a), 32'd15);
        check("a.sat_done", 32'(done_a), 32'd0);
        tick();
        check("a.sat_hold", 32'(fail_a), 32'd15);

        // Async reset mid-CHECK with three failures.
        do_clear();
        for (int n = 0; n < 5; n++) tick();
        check("a.pre_reset_fail", 32'(fail_a), 32'd3);
        check("a.pre_reset_chk",  32'(chk_a),  32'd1);
        #2 reset_n = 1'b0;
        #1 model_reset(0); model_reset(1);
        check_all();
        check("a.reset_fail", 32'(fail_a), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Clear wins over enable and a same-cycle mismatch.
        for (int n = 0; n < 6; n++) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        check("a.clr_fail", 32'(fail_a), 32'd0);
        check("a.clr_err",  32'(err_a),  32'd0);
        check("a.clr_chk",  32'(chk_a),  32'd0);
        tick();
        check("a.clr_fill", 32'(chk_a), 32'd0);
        tick();
        check("a.clr_check", 32'(chk_a), 32'd1);
        enable = 1'b0; tick();
        do_clear();

        // Randomised runs with random faults, aborts and run_len changes mid-run.
        mode = 4;
        for (int r = 0; r < 8; r++) begin
            run_len = 16'($urandom_range(0, 12));
            enable = 1'b1;
            for (int n = 0; n < 30; n++) begin
                set_vec(3'($urandom));
                if ($urandom_range(0, 5) == 0) run_len = 16'($urandom_range(0, 12));
                if ($urandom_range(0, 40) == 0) enable = 1'b0;
                tick();
                enable = 1'b1;
            end
            enable = 1'b0; tick();
            if (r == 4) do_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
